// File: rtl/sign_narrow.sv
// sign_narrow: narrows 32-bit two's-complement values to 17-bit signed
// immediates (inverse of 17->32 sign extension), with wrap or saturate on
// overflow, a one-word stage register feeding a 2-entry output FIFO, and
// overflow statistics on delivered words.
module sign_narrow (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        sat_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_data,
    output logic        out_ovf,
    input  logic        clr,
    output logic [7:0]  ovf_count,
    output logic        ovf_sticky
);

    localparam int DATA_W = 32;
    localparam int OUT_W  = 17;

    // A value fits when every bit above the target sign bit copies it.
    function automatic logic fits_out(input logic signed [DATA_W-1:0] v);
        return (&v[DATA_W-1:OUT_W-1]) | ~(|v[DATA_W-1:OUT_W-1]);
    endfunction

    // Narrowed field: pass-through on fit or wrap, clamp to the extreme of
    // the input's sign when saturating.
    function automatic logic signed [OUT_W-1:0] narrow(
        input logic signed [DATA_W-1:0] v,
        input logic                     sat
    );
        if (fits_out(v) || !sat)
            return v[OUT_W-1:0];
        else if (v[DATA_W-1])
            return 17'h10000;
        else
            return 17'h0FFFF;
    endfunction

    logic signed [OUT_W-1:0] data_p1;
    logic                    ovf_p1;
    logic                    vld_p1;

    logic signed [OUT_W-1:0] data_p2 [2];
    logic                    ovf_p2  [2];
    logic [1:0]              cnt_p2;
    logic                    rd_ptr;
    logic                    wr_ptr;

    logic push;
    logic adv;
    logic pop;
    logic full;

    assign full      = (cnt_p2 == 2'd2);
    assign out_valid = (cnt_p2 != 2'd0);
    assign pop       = out_valid & out_ready;
    assign adv       = vld_p1 & (~full | pop);
    assign in_ready  = reset & (~vld_p1 | adv);
    assign push      = in_valid & in_ready;

    assign out_data  = out_valid ? data_p2[rd_ptr] : '0;
    assign out_ovf   = out_valid & ovf_p2[rd_ptr];

    // Stage 1 payload: narrow the accepted word.
    always_ff @(posedge clock) begin
        if (push) begin
            data_p1 <= narrow(in_data, sat_en);
            ovf_p1  <= ~fits_out(in_data);
        end
    end

    // Stage 2 payload: FIFO storage written as stage 1 advances.
    always_ff @(posedge clock) begin
        if (adv) begin
            data_p2[wr_ptr] <= data_p1;
            ovf_p2[wr_ptr]  <= ovf_p1;
        end
    end

    // Control: stage-1 valid, FIFO occupancy and pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            cnt_p2 <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push)
                vld_p1 <= 1'b1;
            else if (adv)
                vld_p1 <= 1'b0;
            cnt_p2 <= cnt_p2 + {1'b0, adv} - {1'b0, pop};
            if (adv)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

    // Statistics on delivered overflowed words; clr overrides a same-cycle event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_count  <= 8'd0;
            ovf_sticky <= 1'b0;
        end else if (clr) begin
            ovf_count  <= 8'd0;
            ovf_sticky <= 1'b0;
        end else if (pop && out_ovf) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != 8'hFF)
                ovf_count <= ovf_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_sign_narrow.sv
// Testbench for sign_narrow: scoreboard of expected words pushed on input
// handshake, popped and compared by a monitor on each output transfer.
module tb_sign_narrow;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sat_en;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic        out_ovf;
    logic        clr;
    logic [7:0]  ovf_count;
    logic        ovf_sticky;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mcnt   = 0;
    logic msticky = 1'b0;
    logic [17:0] exp_q [$];
    logic [17:0] e;

    sign_narrow dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .clr        (clr),
        .ovf_count  (ovf_count),
        .ovf_sticky (ovf_sticky)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: fits iff sign-extending the low 17 bits restores v.
    function automatic logic [17:0] ref_narrow(input logic [31:0] v, input logic s);
        logic [31:0] sx;
        sx = {{15{v[16]}}, v[16:0]};
        if (sx == v)
            return {1'b0, v[16:0]};
        else if (!s)
            return {1'b1, v[16:0]};
        else
            return {1'b1, (v[31] ? 17'h10000 : 17'h0FFFF)};
    endfunction

    // Monitor: compare every output transfer against the scoreboard and
    // keep the statistics model.
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {15'd0, out_ovf, out_data}, 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {15'd0, out_data}, {15'd0, e[16:0]});
                    check("out_ovf", {31'd0, out_ovf}, {31'd0, e[17]});
                    if (!clr && e[17]) begin
                        msticky = 1'b1;
                        if (mcnt < 255) mcnt = mcnt + 1;
                    end
                end
            end
            if (clr) begin
                mcnt = 0;
                msticky = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic s, input logic [16:0] ed, input logic eo);
        int  n = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_data  = d;
        sat_en   = s;
        while (!done) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back({eo, ed});
                done = 1;
            end
            @(posedge clock);
            #1;
            n++;
            if (!done && n > 200) begin
                check("send_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("queue_drained", exp_q.size(), 32'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int start;
        logic [31:0] r;
        logic        s;

        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        sat_en = 1'b0;
        out_ready = 1'b0;
        clr = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {15'd0, out_data}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        check("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
        check("rst_ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        #11 reset = 1'b1;
        @(posedge clock);
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Boundary fits and overflow modes
        out_ready = 1'b1;
        send(32'h0000FFFF, 1'b0, 17'h0FFFF, 1'b0);
        send(32'hFFFF0000, 1'b0, 17'h10000, 1'b0);
        send(32'h00000000, 1'b0, 17'h00000, 1'b0);
        send(32'hFFFFFFFF, 1'b0, 17'h1FFFF, 1'b0);
        send(32'h00010000, 1'b0, 17'h10000, 1'b1);
        send(32'h00010000, 1'b1, 17'h0FFFF, 1'b1);
        send(32'h80000000, 1'b1, 17'h10000, 1'b1);
        send(32'hFFFEFFFF, 1'b0, 17'h0FFFF, 1'b1);
        in_valid = 1'b0;
        drain();
        check("count_after_modes", {24'd0, ovf_count}, 32'd4);
        check("sticky_after_modes", {31'd0, ovf_sticky}, 32'd1);

        // Backpressure: three accepted, then blocked with a stable head
        out_ready = 1'b0;
        send(32'h00000001, 1'b0, 17'h00001, 1'b0);
        send(32'h7FFFFFFF, 1'b1, 17'h0FFFF, 1'b1);
        send(32'hFFFF8000, 1'b0, 17'h18000, 1'b0);
        in_data = 32'h12345678;
        sat_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_head_stable", {15'd0, out_data}, 32'h00001);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("full_pop_push_ready", {31'd0, in_ready}, 32'd1);
        send(32'h12345678, 1'b0, 17'h05678, 1'b1);
        send(32'hFFFFFFFE, 1'b0, 17'h1FFFE, 1'b0);
        in_valid = 1'b0;
        drain();
        check("count_after_bp", {24'd0, ovf_count}, 32'd6);

        // Latency: accepted at edge N, visible after edge N+1
        send(32'h00000005, 1'b0, 17'h00005, 1'b0);
        in_valid = 1'b0;
        check("latency_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clock);
        #1;
        check("latency_two", {31'd0, out_valid}, 32'd1);
        drain();

        // Throughput: 100 random words back to back
        start = cyc;
        for (int i = 0; i < 100; i++) begin
            case ($urandom_range(0, 3))
                0: r = $urandom & 32'h0000FFFF;
                1: r = {{15{r[16]}}, 17'($urandom)};
                2: r = $urandom ^ 32'h00010000;
                default: r = $urandom;
            endcase
            s = 1'($urandom);
            e = ref_narrow(r, s);
            send(r, s, e[16:0], e[17]);
        end
        check("throughput_cycles", cyc - start, 32'd100);
        in_valid = 1'b0;
        drain();
        check("count_after_random", {24'd0, ovf_count}, mcnt);
        check("sticky_after_random", {31'd0, ovf_sticky}, {31'd0, msticky});

        // Saturating statistics
        for (int i = 0; i < 300; i++) begin
            s = i[0];
            send(32'h40000000, s, s ? 17'h0FFFF : 17'h00000, 1'b1);
        end
        in_valid = 1'b0;
        drain();
        check("count_saturated", {24'd0, ovf_count}, 32'd255);
        check("sticky_saturated", {31'd0, ovf_sticky}, 32'd1);

        // clr coincident with an overflowed pop
        out_ready = 1'b0;
        send(32'h40000000, 1'b0, 17'h00000, 1'b1);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        clr = 1'b1;
        @(posedge clock);
        #1;
        clr = 1'b0;
        check("clr_count", {24'd0, ovf_count}, 32'd0);
        check("clr_sticky", {31'd0, ovf_sticky}, 32'd0);
        send(32'h40000000, 1'b1, 17'h0FFFF, 1'b1);
        in_valid = 1'b0;
        drain();
        check("count_after_clr", {24'd0, ovf_count}, 32'd1);
        check("sticky_after_clr", {31'd0, ovf_sticky}, 32'd1);

        // Reset mid-stream with three words buffered
        out_ready = 1'b0;
        send(32'h00000011, 1'b0, 17'h00011, 1'b0);
        send(32'h00000022, 1'b0, 17'h00022, 1'b0);
        send(32'h00000033, 1'b0, 17'h00033, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_count", {24'd0, ovf_count}, 32'd0);
        check("midrst_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        mcnt = 0;
        msticky = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("no_stale_word", {31'd0, out_valid}, 32'd0);
            @(posedge clock);
            #1;
        end
        send(32'hFFFFFFFF, 1'b0, 17'h1FFFF, 1'b0);
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_narrow.md
# sign_narrow

Streaming narrower that converts 32-bit two's-complement values into 17-bit signed immediate fields, the exact inverse of the processor's 17→32 immediate sign extension. It checks that each value is representable, then either wraps or saturates it, and flags overflow. It sits between the assembler/loader datapath and the instruction-word packer, with valid/ready handshakes on both sides. It buffers up to three words in flight and keeps overflow statistics.

## Interface
Parameters:
- none (widths fixed: 32-bit in, 17-bit out)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- in_data  in  32  two's-complement value to narrow
- sat_en  in  1  per-word: 1 = saturate on overflow, 0 = wrap; sampled with in_data
- out_valid  out  1  output word present
- out_ready  in  1  consumer accepts output this cycle
- out_data  out  17  narrowed immediate
- out_ovf  out  1  this output word was not representable in 17 bits
- clr  in  1  synchronous clear of ovf_count and ovf_sticky
- ovf_count  out  8  saturating count of overflowed words delivered
- ovf_sticky  out  1  set on first overflowed word delivered; held until clr or reset

## Operation
- Fit rule: a value fits iff in_data[31:16] are all equal (i.e. all equal to bit 16). For a fit, out_data = in_data[16:0] and out_ovf = 0.
- Invariant: when out_ovf = 0, sign-extending out_data to 32 bits reproduces in_data exactly.
- Overflow with sat_en = 0: out_data = in_data[16:0] (wrap), out_ovf = 1.
- Overflow with sat_en = 1: out_data = 17'h0FFFF if in_data[31] = 0, else 17'h10000. out_ovf = 1.
- Structure: stage register S1 holds the computed result, ovf and valid. It feeds a 2-entry FIFO whose head drives out_data and out_ovf. Maximum occupancy is 3 words.
- Input transfer occurs on in_valid & in_ready. Output transfer occurs on out_valid & out_ready.
- S1 advances into the FIFO when S1 is valid and the FIFO is not full, or is full but popping this cycle.
- in_ready = !S1_valid | S1 advancing. This is combinational from state and out_ready. in_ready is 0 while reset is low.
- out_valid = FIFO non-empty. There is no combinational path from in_valid to out_valid.
- Words leave strictly in acceptance order; there is no reordering or dropping.
- Statistics: on each output transfer with out_ovf = 1, ovf_count increments (saturating at 255) and ovf_sticky is set.
- clr asserted in the same cycle as a counted transfer: clr wins. Count becomes 0 and sticky becomes 0; that event is not counted.

## Timing
- Reset values: out_valid 0, out_data 0, out_ovf 0, ovf_count 0, ovf_sticky 0, S1 and FIFO empty. in_ready is 1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight words are discarded immediately (asynchronous). There is no partial output.
- Latency: a word accepted at edge N appears at out_valid after edge N+1, i.e. 2 cycles, when the FIFO has room.
- Throughput: 1 word per cycle sustained when out_ready is held at 1.
- Backpressure: with out_ready = 0, the block accepts exactly 3 words. After that, in_ready = 0 until a pop.
- Full with simultaneous pop and push:
  - FIFO full, S1 full, out_ready = 1 → pop, S1 moves into the FIFO, a new word enters S1, and in_ready = 1 in that cycle.
- out_data and out_ovf are stable while out_valid & !out_ready.
- Statistics update on the edge of the output transfer and are visible the next cycle.

## Test plan
1. **Boundary fits** (sat_en = 0, stream out): 0x0000FFFF → 0x0FFFF, ovf 0. 0xFFFF0000 → 0x10000, ovf 0. 0x00000000 → 0x00000, ovf 0. 0xFFFFFFFF → 0x1FFFF, ovf 0.
2. **Overflow modes**:
   - 0x00010000 with sat_en = 0 → 0x10000, ovf 1.
   - 0x00010000 with sat_en = 1 → 0x0FFFF, ovf 1.
   - 0x80000000 with sat_en = 1 → 0x10000, ovf 1.
   - 0xFFFEFFFF with sat_en = 0 → 0x0FFFF, ovf 1.
3. **Backpressure**: out_ready = 0, offer 5 words A–E → A, B, C accepted and in_ready = 0 thereafter. Raise out_ready → A–E delivered in order, one per cycle after D and E enter.
4. **Throughput and latency**: 100 random words with out_ready = 1 → first out_valid 2 cycles after first accept, then one per cycle. Every word matches the reference model.
5. **Statistics**:
   - 300 overflowing words → ovf_count 255, sticky 1.
   - Pulse clr coincident with an overflowed pop → count 0, sticky 0 next cycle.
   - Next overflowed pop → count 1.
6. **Reset mid-stream**: assert reset with 3 words buffered → out_valid drops at once, ovf_count 0. After release, in_ready = 1 and no stale word ever appears.
